// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
// State encoding, ACK levels and the general-call address.
package i2c_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_PTR       = 4'd3,
    S_PTR_ACK   = 4'd4,
    S_WRITE     = 4'd5,
    S_WRITE_ACK = 4'd6,
    S_READ      = 4'd7,
    S_READ_ACK  = 4'd8,
    S_IGNORE    = 4'd9
  } state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam logic [6:0] GEN_CALL_ADDR = 7'h00;

endpackage

// File: rtl/i2c_line_sync.sv
// Multi-flop synchroniser for one bus line plus edge detect.
// Resets to 1 so an idle (released) bus produces no edges.
module i2c_line_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // shift the pin through the chain, keep last level for edges
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_line};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = o_level & ~r_prev;
  assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/i2c_reg_target.sv
// 7-bit I2C target with pointer-based register read/write.
// Define I2C_GEN_CALL_EN to accept general-call writes.
module i2c_reg_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDRESS     = 7'h4A,
  parameter int          NUM_REGS    = 4,
  parameter int          SYNC_STAGES = 2,
  localparam int         PTR_W       = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scl_i,
  output logic             scl_o,
  input  logic             sda_i,
  output logic             sda_o,
  output logic [PTR_W-1:0] reg_addr_o,
  output logic [7:0]       wr_data_o,
  output logic             wr_valid_o,
  output logic             rd_req_o,
  input  logic [7:0]       rd_data_i,
  output logic             start_o,
  output logic             stop_o,
  output logic             busy_o,
  output logic             gen_call_o
);

`ifdef I2C_GEN_CALL_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(NUM_REGS - 1);

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl (
    .clk(clk), .reset(reset), .i_line(scl_i),
    .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda (
    .clk(clk), .reset(reset), .i_line(sda_i),
    .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
  );

  logic w_start, w_stop;
  assign w_start = w_sda_fall & w_scl;
  assign w_stop  = w_sda_rise & w_scl;

  state_t           r_state, w_state;
  logic [3:0]       r_cnt, w_cnt;
  logic [7:0]       r_shift, w_shift;
  logic [PTR_W-1:0] r_ptr, w_ptr;
  logic             r_sda, w_sda_o;
  logic             r_rw, w_rw;
  logic             r_gc, w_gc;
  logic             r_busy, w_busy;
  logic             r_start, w_start_p;
  logic             r_stop, w_stop_p;
  logic             r_wr_valid, w_wr_valid;
  logic [7:0]       r_wr_data, w_wr_data;
  logic             r_rd_req, w_rd_req;
  logic             r_gc_out, w_gc_out;

  logic [7:0]       w_byte;
  logic [PTR_W-1:0] w_ptr_mod;
  logic [PTR_W-1:0] w_ptr_inc;

  assign w_byte    = {r_shift[6:0], w_sda};
  assign w_ptr_mod = PTR_W'(r_shift % 8'(NUM_REGS));
  assign w_ptr_inc = (r_ptr == PTR_MAX) ? '0 : r_ptr + 1'b1;

  // state and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_ptr      <= '0;
      r_sda      <= 1'b1;
      r_rw       <= 1'b0;
      r_gc       <= 1'b0;
      r_busy     <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_data  <= '0;
      r_rd_req   <= 1'b0;
      r_gc_out   <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_shift    <= w_shift;
      r_ptr      <= w_ptr;
      r_sda      <= w_sda_o;
      r_rw       <= w_rw;
      r_gc       <= w_gc;
      r_busy     <= w_busy;
      r_start    <= w_start_p;
      r_stop     <= w_stop_p;
      r_wr_valid <= w_wr_valid;
      r_wr_data  <= w_wr_data;
      r_rd_req   <= w_rd_req;
      r_gc_out   <= w_gc_out;
    end
  end

  // next-state: START/STOP override everything, else bit-level FSM
  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_shift    = r_shift;
    w_ptr      = r_ptr;
    w_sda_o    = r_sda;
    w_rw       = r_rw;
    w_gc       = r_gc;
    w_busy     = r_busy;
    w_start_p  = 1'b0;
    w_stop_p   = 1'b0;
    w_wr_valid = 1'b0;
    w_wr_data  = r_wr_data;
    w_rd_req   = 1'b0;
    w_gc_out   = 1'b0;
    if (r_rd_req) w_shift = rd_data_i;
    if (w_start) begin
      w_state   = S_ADDR;
      w_cnt     = '0;
      w_sda_o   = 1'b1;
      w_start_p = 1'b1;
      w_busy    = 1'b1;
      w_gc      = 1'b0;
    end else if (w_stop) begin
      w_state  = S_IDLE;
      w_sda_o  = 1'b1;
      w_stop_p = 1'b1;
      w_busy   = 1'b0;
    end else begin
      unique case (r_state)
        S_ADDR: begin
          if (w_scl_rise) begin
            w_shift = w_byte;
            w_cnt   = r_cnt + 4'd1;
          end else if (w_scl_fall && r_cnt == 4'd8) begin
            w_cnt = '0;
            if (r_shift[7:1] == ADDRESS) begin
              w_state = S_ADDR_ACK;
              w_sda_o = ACK;
              w_rw    = r_shift[0];
            end else if (GC_EN && r_shift == {GEN_CALL_ADDR, 1'b0}) begin
              w_state = S_ADDR_ACK;
              w_sda_o = ACK;
              w_rw    = 1'b0;
              w_gc    = 1'b1;
            end else begin
              w_state = S_IGNORE;
            end
          end
        end
        S_PTR, S_WRITE: begin
          if (w_scl_rise) begin
            w_shift = w_byte;
            w_cnt   = r_cnt + 4'd1;
            if (r_state == S_WRITE && r_cnt == 4'd7) begin
              w_wr_valid = 1'b1;
              w_wr_data  = w_byte;
              w_gc_out   = r_gc;
            end
          end else if (w_scl_fall && r_cnt == 4'd8) begin
            w_cnt   = '0;
            w_sda_o = ACK;
            if (r_state == S_PTR) begin
              w_ptr   = w_ptr_mod;
              w_state = S_PTR_ACK;
            end else begin
              w_state = S_WRITE_ACK;
            end
          end
        end
        S_ADDR_ACK: begin
          if (w_scl_rise) begin
            w_cnt    = 4'd1;
            w_rd_req = r_rw;
          end else if (w_scl_fall && r_cnt == 4'd1) begin
            w_cnt = '0;
            if (r_rw) begin
              w_state = S_READ;
              w_sda_o = r_shift[7];
              w_shift = {r_shift[6:0], 1'b0};
            end else begin
              w_state = r_gc ? S_WRITE : S_PTR;
              w_sda_o = 1'b1;
            end
          end
        end
        S_PTR_ACK, S_WRITE_ACK: begin
          if (w_scl_rise) begin
            w_cnt = 4'd1;
          end else if (w_scl_fall && r_cnt == 4'd1) begin
            w_cnt   = '0;
            w_state = S_WRITE;
            w_sda_o = 1'b1;
            if (r_state == S_WRITE_ACK && !r_gc) w_ptr = w_ptr_inc;
          end
        end
        S_READ: begin
          if (w_scl_rise) begin
            w_cnt = r_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_cnt == 4'd8) begin
              w_state = S_READ_ACK;
              w_cnt   = '0;
              w_sda_o = 1'b1;
            end else begin
              w_sda_o = r_shift[7];
              w_shift = {r_shift[6:0], 1'b0};
            end
          end
        end
        S_READ_ACK: begin
          if (w_scl_rise) begin
            if (w_sda == NACK) begin
              w_state = S_IGNORE;
            end else begin
              w_cnt    = 4'd1;
              w_ptr    = w_ptr_inc;
              w_rd_req = 1'b1;
            end
          end else if (w_scl_fall && r_cnt == 4'd1) begin
            w_cnt   = '0;
            w_state = S_READ;
            w_sda_o = r_shift[7];
            w_shift = {r_shift[6:0], 1'b0};
          end
        end
        S_IDLE, S_IGNORE: begin
          w_sda_o = 1'b1;
        end
        default: begin
          w_state = S_IDLE;
          w_sda_o = 1'b1;
        end
      endcase
    end
  end

  assign scl_o      = 1'b1;
  assign sda_o      = r_sda;
  assign reg_addr_o = r_ptr;
  assign wr_data_o  = r_wr_data;
  assign wr_valid_o = r_wr_valid;
  assign rd_req_o   = r_rd_req;
  assign start_o    = r_start;
  assign stop_o     = r_stop;
  assign busy_o     = r_busy;
  assign gen_call_o = r_gc_out;

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench for i2c_reg_target: host bit-bang model,
// scoreboard queues for write strobes and read requests.
module tb_i2c_reg_target;

`ifdef I2C_GEN_CALL_EN
  localparam bit GC = 1'b1;
`else
  localparam bit GC = 1'b0;
`endif

  localparam int Q = 10;

  typedef struct packed {
    logic [1:0] a;
    logic [7:0] d;
    logic       gc;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       host_scl, host_sda;
  logic       scl_i, scl_o, sda_i, sda_o;
  logic [1:0] reg_addr_o;
  logic [7:0] wr_data_o, rd_data_i;
  logic       wr_valid_o, rd_req_o;
  logic       start_o, stop_o, busy_o, gen_call_o;

  int checks = 0;
  int fails  = 0;
  int n_start = 0;
  int n_stop  = 0;
  int n_low   = 0;

  wr_t        exp_wr[$];
  logic [1:0] exp_rd[$];

  assign scl_i = host_scl & scl_o;
  assign sda_i = host_sda & sda_o;

  always #5 clk = ~clk;

  i2c_reg_target #(
    .ADDRESS(7'h4A), .NUM_REGS(4), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset),
    .scl_i(scl_i), .scl_o(scl_o),
    .sda_i(sda_i), .sda_o(sda_o),
    .reg_addr_o(reg_addr_o),
    .wr_data_o(wr_data_o), .wr_valid_o(wr_valid_o),
    .rd_req_o(rd_req_o), .rd_data_i(rd_data_i),
    .start_o(start_o), .stop_o(stop_o),
    .busy_o(busy_o), .gen_call_o(gen_call_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard pop for write strobes
  always @(negedge clk) begin
    if (wr_valid_o) begin
      chk("wr_expected", 32'(exp_wr.size() > 0), 32'd1);
      if (exp_wr.size() > 0)
        chk("wr_strobe", 32'({reg_addr_o, wr_data_o, gen_call_o}),
            32'(exp_wr.pop_front()));
    end
    if (rd_req_o) begin
      chk("rd_expected", 32'(exp_rd.size() > 0), 32'd1);
      if (exp_rd.size() > 0)
        chk("rd_req_addr", 32'(reg_addr_o), 32'(exp_rd.pop_front()));
    end
    if (start_o) n_start++;
    if (stop_o) n_stop++;
    if (!sda_o) n_low++;
  end

  task automatic wq(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clk_bit(input logic b, output logic r);
    host_sda = b;
    wq(Q);
    host_scl = 1'b1;
    wq(Q);
    r = sda_i;
    wq(Q);
    host_scl = 1'b0;
    wq(Q);
  endtask

  task automatic i2c_start();
    if (host_scl == 1'b0) begin
      host_sda = 1'b1;
      wq(Q);
      host_scl = 1'b1;
      wq(Q);
    end
    host_sda = 1'b0;
    wq(Q);
    host_scl = 1'b0;
    wq(Q);
  endtask

  task automatic i2c_stop();
    host_sda = 1'b0;
    wq(Q);
    host_scl = 1'b1;
    wq(Q);
    host_sda = 1'b1;
    wq(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], r);
    clk_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, r);
      d[i] = r;
    end
    clk_bit(nack, r);
  endtask

  logic       ack;
  logic       r;
  logic [7:0] rd;
  int         s0;

  initial begin
    reset     = 1'b0;
    host_scl  = 1'b1;
    host_sda  = 1'b1;
    rd_data_i = 8'h5C;
    wq(5);
    chk("rst_sda", 32'(sda_o), 32'd1);
    chk("rst_scl", 32'(scl_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_ptr", 32'(reg_addr_o), 32'd0);
    chk("rst_wdata", 32'(wr_data_o), 32'd0);
    chk("rst_pulses",
        32'({wr_valid_o, rd_req_o, start_o, stop_o, gen_call_o}), 32'd0);
    reset = 1'b1;
    wq(5);

    // 1: pointer write plus two data bytes
    s0 = n_stop;
    i2c_start();
    chk("t1_busy", 32'(busy_o), 32'd1);
    wr_byte(8'h94, ack); chk("t1_ack_addr", 32'(ack), 32'd1);
    wr_byte(8'h01, ack); chk("t1_ack_ptr", 32'(ack), 32'd1);
    exp_wr.push_back('{a: 2'd1, d: 8'h71, gc: 1'b0});
    wr_byte(8'h71, ack); chk("t1_ack_d0", 32'(ack), 32'd1);
    exp_wr.push_back('{a: 2'd2, d: 8'hA8, gc: 1'b0});
    wr_byte(8'hA8, ack); chk("t1_ack_d1", 32'(ack), 32'd1);
    i2c_stop();
    wq(5);
    chk("t1_stop", 32'(n_stop - s0), 32'd1);
    chk("t1_idle", 32'(busy_o), 32'd0);
    chk("t1_ptr", 32'(reg_addr_o), 32'd3);

    // 2: pointer wrap
    i2c_start();
    wr_byte(8'h94, ack); chk("t2_ack_addr", 32'(ack), 32'd1);
    wr_byte(8'h03, ack); chk("t2_ack_ptr", 32'(ack), 32'd1);
    exp_wr.push_back('{a: 2'd3, d: 8'h11, gc: 1'b0});
    wr_byte(8'h11, ack); chk("t2_ack_d0", 32'(ack), 32'd1);
    exp_wr.push_back('{a: 2'd0, d: 8'h22, gc: 1'b0});
    wr_byte(8'h22, ack); chk("t2_ack_d1", 32'(ack), 32'd1);
    i2c_stop();
    wq(5);
    chk("t2_ptr", 32'(reg_addr_o), 32'd1);

    // 3: set pointer, repeated START, read with NACK
    s0 = n_start;
    i2c_start();
    wr_byte(8'h94, ack); chk("t3_ack_addr", 32'(ack), 32'd1);
    wr_byte(8'h02, ack); chk("t3_ack_ptr", 32'(ack), 32'd1);
    i2c_start();
    exp_rd.push_back(2'd2);
    wr_byte(8'h95, ack); chk("t3_ack_raddr", 32'(ack), 32'd1);
    rd_byte(1'b1, rd);
    chk("t3_rdata", 32'(rd), 32'h5C);
    i2c_stop();
    wq(5);
    chk("t3_starts", 32'(n_start - s0), 32'd2);
    chk("t3_ptr", 32'(reg_addr_o), 32'd2);

    // 3b: two-byte read with host ACK then NACK
    i2c_start();
    exp_rd.push_back(2'd2);
    exp_rd.push_back(2'd3);
    wr_byte(8'h95, ack); chk("t3b_ack", 32'(ack), 32'd1);
    rd_byte(1'b0, rd); chk("t3b_rd0", 32'(rd), 32'h5C);
    rd_byte(1'b1, rd); chk("t3b_rd1", 32'(rd), 32'h5C);
    i2c_stop();
    wq(5);
    chk("t3b_ptr", 32'(reg_addr_o), 32'd3);

    // 4: foreign address is ignored
    i2c_start();
    n_low = 0;
    wr_byte(8'h96, ack); chk("t4_nack_addr", 32'(ack), 32'd0);
    wr_byte(8'h55, ack); chk("t4_nack_data", 32'(ack), 32'd0);
    i2c_stop();
    wq(5);
    chk("t4_sda_low", 32'(n_low), 32'd0);

    // 5: reset in the 4th data bit
    i2c_start();
    wr_byte(8'h94, ack); chk("t5_ack_addr", 32'(ack), 32'd1);
    wr_byte(8'h01, ack); chk("t5_ack_ptr", 32'(ack), 32'd1);
    clk_bit(1'b0, r);
    clk_bit(1'b0, r);
    clk_bit(1'b1, r);
    host_sda = 1'b1;
    wq(Q);
    host_scl = 1'b1;
    wq(5);
    reset = 1'b0;
    wq(3);
    chk("t5_sda", 32'(sda_o), 32'd1);
    chk("t5_busy", 32'(busy_o), 32'd0);
    chk("t5_ptr", 32'(reg_addr_o), 32'd0);
    reset = 1'b1;
    wq(2 * Q);
    i2c_start();
    wr_byte(8'h94, ack); chk("t5_re_ack_addr", 32'(ack), 32'd1);
    wr_byte(8'h02, ack); chk("t5_re_ack_ptr", 32'(ack), 32'd1);
    exp_wr.push_back('{a: 2'd2, d: 8'h33, gc: 1'b0});
    wr_byte(8'h33, ack); chk("t5_re_ack_d", 32'(ack), 32'd1);
    i2c_stop();
    wq(5);

    // 6: general call
    i2c_start();
    wr_byte(8'h00, ack); chk("t6_gc_addr", 32'(ack), 32'(GC));
    if (GC) exp_wr.push_back('{a: 2'd3, d: 8'h06, gc: 1'b1});
    wr_byte(8'h06, ack); chk("t6_gc_data", 32'(ack), 32'(GC));
    i2c_stop();
    wq(5);
    chk("t6_ptr", 32'(reg_addr_o), 32'd3);

    wq(20);
    chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
